// File: rtl/line_fetch_scheduler.sv
// Ping-pong line prefetcher: fills the inactive line bank from frame memory during
// each scan line, swaps banks at end of line and streams registered pixels from the active bank.
module line_fetch_scheduler #(
    parameter int H_ACTIVE = 1280,
    parameter int H_TOTAL  = 1688,
    parameter int V_ACTIVE = 1024,
    parameter int V_TOTAL  = 1066,
    parameter int WORD_W   = 16,
    parameter int ADDR_W   = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [10:0]       CounterX,
    input  logic [10:0]       CounterY,
    input  logic              inDisplayArea,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [WORD_W-1:0] mem_data,
    output logic              pixel,
    output logic              fetch_busy,
    output logic              underrun
);

    localparam int WORDS = H_ACTIVE / WORD_W;
    localparam int WI_W  = $clog2(WORDS);
    localparam int BIT_W = $clog2(WORD_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [WI_W-1:0]   word_index, word_index_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic              req_nxt;
    logic              active_bank;
    logic              bank_valid, bank_valid_nxt;
    logic              underrun_nxt;

    logic [10:0]       next_y;
    logic              sched;
    logic              at_line_start;
    logic              at_swap;
    logic              wr_en;
    logic              last_ack;
    logic              fetch_complete;

    logic [WORD_W-1:0] buf_mem [0:1][0:WORDS-1];

    logic              in_active_p0;
    logic [WI_W-1:0]   rd_word_p0;
    logic [BIT_W-1:0]  rd_bit_p0;
    logic [WORD_W-1:0] rd_data_p0;
    logic              pixel_p0;

    // The sync generator's visible flag is only a timing reference for pixel alignment.
    logic              unused_in;
    assign unused_in = inDisplayArea;

    function automatic logic [ADDR_W-1:0] line_base(input logic [10:0] y);
        return ADDR_W'(y) * ADDR_W'(WORDS);
    endfunction

    assign next_y        = (CounterY == 11'(V_TOTAL - 1)) ? 11'd0 : CounterY + 11'd1;
    assign sched         = (next_y < 11'(V_ACTIVE));
    assign at_line_start = (CounterX == 11'd0);
    assign at_swap       = (CounterX == 11'(H_TOTAL - 1));
    assign wr_en         = (state == REQ) && mem_ack;
    assign last_ack      = wr_en && (word_index == WI_W'(WORDS - 1));
    assign fetch_complete = (state == DONE) || last_ack;

    always_comb begin
        state_nxt      = state;
        word_index_nxt = word_index;
        addr_nxt       = mem_addr;
        bank_valid_nxt = bank_valid;
        underrun_nxt   = underrun;

        case (state)
            IDLE: begin
                if (at_line_start && sched) begin
                    state_nxt      = REQ;
                    word_index_nxt = '0;
                    addr_nxt       = line_base(next_y);
                end
            end
            REQ: begin
                if (mem_ack) begin
                    if (word_index == WI_W'(WORDS - 1)) begin
                        state_nxt = DONE;
                    end else begin
                        word_index_nxt = word_index + 1'b1;
                        addr_nxt       = mem_addr + 1'b1;
                    end
                end
            end
            default: ;
        endcase

        // Leaving IDLE only happens at line start, so a non-IDLE state here means a fetch was scheduled.
        if (at_swap) begin
            state_nxt      = IDLE;
            bank_valid_nxt = fetch_complete;
            if ((state != IDLE) && !fetch_complete) begin
                underrun_nxt = 1'b1;
            end
        end
    end

    assign req_nxt = (state_nxt == REQ);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            word_index  <= '0;
            mem_addr    <= '0;
            mem_req     <= 1'b0;
            fetch_busy  <= 1'b0;
            active_bank <= 1'b0;
            bank_valid  <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            state       <= state_nxt;
            word_index  <= word_index_nxt;
            mem_addr    <= addr_nxt;
            mem_req     <= req_nxt;
            fetch_busy  <= req_nxt;
            active_bank <= active_bank ^ at_swap;
            bank_valid  <= bank_valid_nxt;
            underrun    <= underrun_nxt;
        end
    end

    // Fetched words always land in the bank not being displayed.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            buf_mem[~active_bank][word_index] <= mem_data;
        end
    end

    // Stage p0: combinational bank read addressed straight from the counters.
    assign in_active_p0 = bank_valid && (CounterX < 11'(H_ACTIVE)) && (CounterY < 11'(V_ACTIVE));
    assign rd_word_p0   = in_active_p0 ? WI_W'(CounterX >> BIT_W) : '0;
    assign rd_bit_p0    = CounterX[BIT_W-1:0];
    assign rd_data_p0   = buf_mem[active_bank][rd_word_p0];
    assign pixel_p0     = in_active_p0 && rd_data_p0[rd_bit_p0];

    // Stage p1: registered pixel, aligned with the sync generator's visible flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pixel <= 1'b0;
        end else begin
            pixel <= pixel_p0;
        end
    end

endmodule

// File: tb/tb_line_fetch_scheduler.sv
// Randomized line-by-line bench for line_fetch_scheduler against a queue-based reference model.
module tb_line_fetch_scheduler;

    localparam int H_ACTIVE = 1280;
    localparam int H_TOTAL  = 1688;
    localparam int V_ACTIVE = 1024;
    localparam int V_TOTAL  = 1066;
    localparam int WORD_W   = 16;
    localparam int ADDR_W   = 17;
    localparam int WORDS    = H_ACTIVE / WORD_W;

    localparam int M_ZERO    = 0;
    localparam int M_EVERY25 = 1;
    localparam int M_RAND    = 2;
    localparam int M_LATE    = 3;
    localparam int M_PATTERN = 4;
    localparam int M_RST40   = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [10:0]       CounterX = '0;
    logic [10:0]       CounterY = '0;
    logic              inDisplayArea = 1'b0;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack = 1'b0;
    logic [WORD_W-1:0] mem_data = '0;
    logic              pixel;
    logic              fetch_busy;
    logic              underrun;

    line_fetch_scheduler #(
        .H_ACTIVE(H_ACTIVE), .H_TOTAL(H_TOTAL), .V_ACTIVE(V_ACTIVE),
        .V_TOTAL(V_TOTAL), .WORD_W(WORD_W), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst(rst), .CounterX(CounterX), .CounterY(CounterY),
        .inDisplayArea(inDisplayArea), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_data(mem_data), .pixel(pixel),
        .fetch_busy(fetch_busy), .underrun(underrun)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cur_x   = 0;
    int cur_y   = 0;
    int align_y = -1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s (y=%0d x=%0d): got %0h, expected %0h", tag, cur_y, cur_x, obs, exp);
        end
    endtask

    // Reference model: a line is a queue of fetched words; it becomes the displayed line
    // at end of line only if all WORDS arrived.
    bit          m_started;
    bit          m_req;
    bit          m_valid;
    bit          m_under;
    bit          m_pixel;
    int          m_base;
    logic [16:0] m_addr;
    logic [15:0] m_q[$];
    logic [15:0] m_disp[WORDS];

    task automatic model_reset();
        m_started = 1'b0;
        m_req     = 1'b0;
        m_valid   = 1'b0;
        m_under   = 1'b0;
        m_pixel   = 1'b0;
        m_base    = 0;
        m_addr    = '0;
        m_q.delete();
    endtask

    task automatic model_step(input int x, input int y, input bit ack, input logic [15:0] data);
        int tgt;
        if (rst) begin
            model_reset();
            return;
        end
        m_pixel = (m_valid && x < H_ACTIVE && y < V_ACTIVE) ? m_disp[x / WORD_W][x % WORD_W] : 1'b0;
        if (m_req && ack) m_q.push_back(data);
        tgt = (y == V_TOTAL - 1) ? 0 : y + 1;
        if (x == 0 && !m_started && tgt < V_ACTIVE) begin
            m_started = 1'b1;
            m_base    = tgt * WORDS;
            m_q.delete();
        end
        if (m_started) m_addr = 17'(m_base + ((m_q.size() < WORDS) ? m_q.size() : WORDS - 1));
        if (x == H_TOTAL - 1) begin
            if (m_started && m_q.size() == WORDS) begin
                for (int i = 0; i < WORDS; i++) m_disp[i] = m_q[i];
                m_valid = 1'b1;
            end else begin
                m_valid = 1'b0;
            end
            if (m_started && m_q.size() != WORDS) m_under = 1'b1;
            m_started = 1'b0;
            m_q.delete();
        end
        m_req = m_started && (m_q.size() < WORDS);
    endtask

    task automatic run_line(input int y, input int mode, input int pct);
        bit          ack;
        bit          vis;
        bit          did_rst;
        logic [15:0] data;
        did_rst = 1'b0;
        if (rst) rst = 1'b0;
        for (int x = 0; x < H_TOTAL; x++) begin
            cur_x = x;
            cur_y = y;
            case (mode)
                M_EVERY25: ack = m_req && (x % 25 == 0);
                M_RAND:    ack = m_req && ($urandom_range(0, 99) < pct);
                M_LATE:    ack = m_req && (x >= H_TOTAL - WORDS);
                default:   ack = m_req;
            endcase
            if (rst) ack = 1'b0;
            data = 16'($urandom);
            if (mode == M_PATTERN) data = (m_q.size() == 0) ? 16'h0001 : 16'h0000;
            CounterX = 11'(x);
            CounterY = 11'(y);
            mem_ack  = ack;
            mem_data = data;
            vis = (x < H_ACTIVE) && (y < V_ACTIVE);
            @(posedge clk);
            inDisplayArea = vis;
            model_step(x, y, ack, data);
            #1;
            check_eq("mem_req", mem_req, m_req);
            check_eq("fetch_busy", fetch_busy, m_req);
            check_eq("mem_addr", mem_addr, m_addr);
            check_eq("pixel", pixel, m_pixel);
            check_eq("underrun", underrun, m_under);
            if (y == align_y && x == 0) check_eq("pix_align", {inDisplayArea, pixel}, 2'b11);
            if (mode == M_RST40 && !did_rst && m_q.size() == 40) begin
                rst = 1'b1;
                did_rst = 1'b1;
                #1;
                check_eq("rst_mem_req", mem_req, 1'b0);
                check_eq("rst_fetch_busy", fetch_busy, 1'b0);
                model_reset();
            end
        end
    endtask

    initial begin
        int y;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        check_eq("reset_mem_req", mem_req, 1'b0);
        check_eq("reset_mem_addr", mem_addr, 17'd0);
        check_eq("reset_pixel", pixel, 1'b0);
        check_eq("reset_fetch_busy", fetch_busy, 1'b0);
        check_eq("reset_underrun", underrun, 1'b0);

        run_line(5, M_ZERO, 0);
        run_line(6, M_RAND, 60);
        run_line(7, M_RAND, 40);

        run_line(1022, M_RAND, 50);
        run_line(1023, M_ZERO, 0);
        run_line(1024, M_ZERO, 0);
        run_line(1065, M_ZERO, 0);

        run_line(0, M_LATE, 0);
        check_eq("late_ack_no_underrun", underrun, 1'b0);
        align_y = 2;
        run_line(1, M_PATTERN, 0);
        run_line(2, M_RST40, 0);
        align_y = -1;
        run_line(3, M_ZERO, 0);
        run_line(4, M_RAND, 50);

        run_line(5, M_EVERY25, 0);
        check_eq("underrun_set", underrun, 1'b1);
        run_line(6, M_ZERO, 0);
        run_line(7, M_RAND, 50);
        check_eq("underrun_sticky", underrun, 1'b1);

        for (int i = 0; i < 6; i++) begin
            y = $urandom_range(0, V_TOTAL - 1);
            run_line(y, M_RAND, $urandom_range(3, 12));
            run_line((y == V_TOTAL - 1) ? 0 : y + 1, M_RAND, $urandom_range(3, 12));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
